serial_alu_seq: RTL and testbench

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

---
 rtl/serial_alu_seq.sv | 179 +++++++++++++++++
 tb/tb_serial_alu_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one result bit per clock, LSB first, through a single-bit
// logic/adder cell. Flags are captured on the edge that processes the MSB.
module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Single-bit cell: returns {carry_out, sum}. Reserved codes yield zero.
    function automatic logic [1:0] bit_cell(input logic [2:0] op_code,
                                            input logic a_bit,
                                            input logic b_bit,
                                            input logic c_in);
        logic b_eff;
        b_eff = (op_code == OP_SUB) ? ~b_bit : b_bit;
        case (op_code)
            OP_NOT:  bit_cell = {1'b0, ~a_bit};
            OP_AND:  bit_cell = {1'b0, a_bit & b_bit};
            OP_OR:   bit_cell = {1'b0, a_bit | b_bit};
            OP_XOR:  bit_cell = {1'b0, a_bit ^ b_bit};
            OP_ADD,
            OP_SUB:  bit_cell = {(a_bit & b_eff) | (a_bit & c_in) | (b_eff & c_in),
                                 a_bit ^ b_eff ^ c_in};
            default: bit_cell = 2'b00;
        endcase
    endfunction

    function automatic logic is_arith(input logic [2:0] op_code);
        is_arith = (op_code == OP_ADD) || (op_code == OP_SUB);
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [2:0]        op_r;
    logic [IDX_W-1:0]  idx_r;
    logic              carry_r;
    logic [WIDTH-1:0]  result_r;
    logic              carry_out_r;
    logic              overflow_r;
    logic              zero_r;
    logic [1:0]        cell_s;
    logic [WIDTH-1:0]  result_next_s;
    logic              last_bit_s;
    logic              ready_s;
    logic              out_valid_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_next_s = S_RUN;
                else       state_next_s = S_IDLE;
            end
            S_RUN: begin
                if (last_bit_s) state_next_s = S_DONE;
                else            state_next_s = S_RUN;
            end
            S_DONE: begin
                if (out_ready) state_next_s = S_IDLE;
                else           state_next_s = S_DONE;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        ready_s     = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            S_IDLE:  ready_s     = 1'b1;
            S_DONE:  out_valid_s = 1'b1;
            default: begin
                ready_s     = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Current bit through the cell, and the result as it will be after this edge.
    always_comb begin
        cell_s                = bit_cell(op_r, a_r[idx_r], b_r[idx_r], carry_r);
        result_next_s         = result_r;
        result_next_s[idx_r]  = cell_s[0];
        last_bit_s            = (idx_r == LAST_IDX);
    end

    // Operand latch, serial datapath and flag capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            op_r        <= 3'b000;
            idx_r       <= {IDX_W{1'b0}};
            carry_r     <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r         <= a;
                        b_r         <= b;
                        op_r        <= op;
                        idx_r       <= {IDX_W{1'b0}};
                        carry_r     <= (op == OP_SUB);
                        result_r    <= {WIDTH{1'b0}};
                        carry_out_r <= 1'b0;
                        overflow_r  <= 1'b0;
                        zero_r      <= 1'b0;
                    end
                end
                S_RUN: begin
                    result_r <= result_next_s;
                    carry_r  <= cell_s[1];
                    idx_r    <= idx_r + IDX_W'(1);
                    // carry_r here is the carry into the MSB when on the last bit
                    if (last_bit_s) begin
                        carry_out_r <= is_arith(op_r) & cell_s[1];
                        overflow_r  <= is_arith(op_r) & (carry_r ^ cell_s[1]);
                        zero_r      <= (result_next_s == {WIDTH{1'b0}});
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready     = ready_s;
    assign out_valid = out_valid_s;
    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq at WIDTH=8: vector table plus
// hand-written sequences for DONE hold and mid-operation reset.
module tb_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int n_vec = 0;
    int n_err = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({name, " ready_wait"}, 64'(ready), 64'd1);
    endtask

    // Accept one op, scramble inputs afterwards, and check latency and outputs.
    task automatic run_op(input string name, input vec_t v);
        int n;
        wait_ready(name);
        op = v.op; a = v.a; b = v.b; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~v.a; b = v.a ^ v.b; op = v.op ^ 3'b101;
        check({name, " busy"}, 64'(ready), 64'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({name, " latency"}, 64'(n), 64'd8);
        check({name, " result"}, 64'(result), 64'(v.res));
        check({name, " carry"}, 64'(carry_out), 64'(v.c));
        check({name, " ovf"}, 64'(overflow), 64'(v.v));
        check({name, " zero"}, 64'(zero), 64'(v.z));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " ack_valid"}, 64'(out_valid), 64'd0);
        check({name, " ack_ready"}, 64'(ready), 64'd1);
    endtask

    initial begin
        vec_t v;
        int   n;
        //          op      a      b      res    c     v     z
        vecs[0]  = '{3'b100, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'b101, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{3'b101, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b000, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b010, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b011, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b111, 8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{3'b110, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b100, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{3'b101, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{3'b100, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{3'b101, 8'h7F, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{3'b100, 8'h3C, 8'h5A, 8'h96, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst ready", 64'(ready), 64'd1);
        check("rst valid", 64'(out_valid), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst flags", 64'({carry_out, overflow, zero}), 64'd0);

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // DONE hold: start pulses and operand changes ignored while out_ready=0.
        wait_ready("hold");
        op = 3'b100; a = 8'h10; b = 8'h20; start = 1'b1;
        tick();
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            a = a + 8'h11; b = b ^ 8'h5A;
            tick();
            n++;
        end
        check("hold latency", 64'(n), 64'd8);
        for (int k = 0; k < 5; k++) begin
            start = k[0]; a = 8'(k * 37); b = ~a;
            tick();
            check($sformatf("hold result%0d", k), 64'(result), 64'h30);
            check($sformatf("hold ready%0d", k), 64'(ready), 64'd0);
            check($sformatf("hold valid%0d", k), 64'(out_valid), 64'd1);
        end
        start = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold release valid", 64'(out_valid), 64'd0);
        check("hold release ready", 64'(ready), 64'd1);
        op = 3'b011; a = 8'h0F; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b accepted", 64'(ready), 64'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("b2b latency", 64'(n), 64'd8);
        check("b2b result", 64'(result), 64'hF0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset on the edge that would process bit 4, with start also high.
        wait_ready("rstmid");
        op = 3'b100; a = 8'h77; b = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0; start = 1'b1;
        tick();
        rst_n = 1'b1; start = 1'b0;
        check("rstmid ready", 64'(ready), 64'd1);
        check("rstmid valid", 64'(out_valid), 64'd0);
        check("rstmid result", 64'(result), 64'd0);
        check("rstmid flags", 64'({carry_out, overflow, zero}), 64'd0);
        tick();
        check("rstmid start ignored", 64'(ready), 64'd1);
        v = '{3'b100, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0};
        run_op("post_rst", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
